mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Moore-style control FSM that sequences a multi-cycle MIPS datapath built from the existing PC, ALU_32, shift and mux blocks with one shared ALU and one unified memory. Each instruction splits into fetch, decode, execute, memory and writeback steps. Memory steps stall on a ready handshake, guarded by a watchdog. The block also keeps a retired-instruction counter. It sits beside the datapath top and drives every datapath enable and mux select.

Parameters:
WAIT_LIMIT, 255, maximum cycles spent waiting on mem_ready in a single memory state before timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
pc_en  out  1  PC register write enable (unconditional or branch-taken)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  write register select: 0 = rt, 1 = rd
mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = A register
alu_src_b  out  2  00 = B, 01 = 4, 10 = SEImm, 11 = SEImm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump address
illegal  out  1  one-cycle pulse on an unsupported opcode
mem_timeout  out  1  sticky; set when the watchdog expires, cleared only by reset
state  out  4  current state encoding, for debug
instr_count  out  CNT_W  retired instructions

Behaviour:
- One clock, clk. Reset reset_n is asynchronous, active-low.
- Reset: state = IDLE, instr_count = 0, mem_timeout = 0, wait counter = 0. All outputs are 0 while in IDLE.
- IDLE always moves to FETCH on the next clk. The first fetch read is issued in the first cycle after reset deasserts.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_en are asserted only in the cycle mem_ready=1, and the FSM moves to DECODE in that same cycle. Otherwise it holds.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDI_EX
  - any other opcode -> FETCH with illegal=1 for that cycle; instr_count does not increment
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Moves to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Holds until mem_ready, then moves to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Retires, then FETCH.
- MEM_WR: mem_write=1, iord=1. Holds until mem_ready, then retires and moves to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retires, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero. Retires, then FETCH.
- JUMP: pc_source=10, pc_en=1. Retires, then FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00, then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Retires, then FETCH.
- Signals not listed for a state are 0 in that state.
- CPI: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, each with zero-wait memory. Every mem_ready=0 cycle adds one cycle.
- Watchdog:
  - The wait counter clears on entry to FETCH, MEM_RD or MEM_WR.
  - It increments on each cycle in those states with mem_ready=0.
  - If it reaches WAIT_LIMIT while mem_ready is still 0, mem_timeout is set and the FSM moves to HALT.
  - mem_ready=1 in the cycle the counter equals WAIT_LIMIT counts as success, not timeout.
- HALT: all strobes 0, state held until reset.
- Retire: instr_count increments by 1 on the transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or ADDI_WB. It wraps modulo 2^CNT_W.
- Reset asserted mid-instruction: immediately returns to IDLE and drops all strobes. Any in-flight memory access is abandoned.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - the state enum: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB, HALT
  - alu_src_b, alu_op and pc_source encodings
- One sub-module, mem_wait_watchdog: wait counter plus sticky mem_timeout; inputs are the waiting flag, mem_ready and a clear.

Test Plan:
- Reset release, mem_ready tied 1, opcode=000000 -> states IDLE, FETCH, DECODE, EXEC, R_WB, FETCH; reg_write=1, reg_dst=1 in R_WB; instr_count=1 after 5 cycles.
- lw (100011) with mem_ready low for 3 cycles in FETCH and 2 in MEM_RD -> ir_write/pc_en pulse only on the ready cycle; 10 cycles FETCH to FETCH; mem_to_reg=1 in MEM_WB.
- beq (000100) with zero=1, then again with zero=0 -> pc_en=1, pc_source=01 in BRANCH for the first; pc_en=0 for the second; both retire.
- opcode=111111 -> illegal pulses 1 cycle in DECODE, next state FETCH, instr_count unchanged.
- WAIT_LIMIT=4, mem_ready held 0 in MEM_WR -> mem_timeout=1 after 4 waiting cycles, state=HALT; mem_ready=1 on the 4th cycle instead -> no timeout, FETCH.
- Assert reset_n=0 during MEM_RD -> same cycle, mem_read=0 and state=IDLE asynchronously; instr_count=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS control FSM: opcodes, states,
// datapath select encodings and the per-state registered control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        EXEC, R_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB, HALT
    } state_t;

    typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH} alu_src_b_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} alu_op_t;
    typedef enum logic [1:0] {PCS_ALU, PCS_ALUOUT, PCS_JUMP} pc_source_t;

    // Control bits that depend only on the state; ready/zero/opcode
    // qualified strobes are formed separately in the top.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_source_t pc_source;
    } ctrl_out_t;

    function automatic ctrl_out_t state_outputs(state_t s);
        ctrl_out_t o;
        o = '0;
        case (s)
            FETCH:    begin o.mem_read = 1'b1; o.alu_src_b = SRCB_FOUR; end
            DECODE:   o.alu_src_b = SRCB_IMM_SH;
            MEM_ADDR: begin o.alu_src_a = 1'b1; o.alu_src_b = SRCB_IMM; end
            MEM_RD:   begin o.mem_read = 1'b1; o.iord = 1'b1; end
            MEM_WB:   begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            MEM_WR:   begin o.mem_write = 1'b1; o.iord = 1'b1; end
            EXEC:     begin o.alu_src_a = 1'b1; o.alu_op = ALU_FUNCT; end
            R_WB:     begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
            BRANCH:   begin o.alu_src_a = 1'b1; o.alu_op = ALU_SUB; o.pc_source = PCS_ALUOUT; end
            JUMP:     o.pc_source = PCS_JUMP;
            ADDI_EX:  begin o.alu_src_a = 1'b1; o.alu_src_b = SRCB_IMM; end
            ADDI_WB:  o.reg_write = 1'b1;
            default:  o = '0;
        endcase
        return o;
    endfunction

    function automatic logic is_legal(logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the FSM (slave side) and the datapath/bench (master side).
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_en;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal;
    logic             mem_timeout;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal,
               mem_timeout, state, instr_count
    );
    modport slave (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal,
               mem_timeout, state, instr_count
    );
endinterface

// File: rtl/mem_wait_watchdog.sv
// Counts stalled cycles in a memory-waiting state; flags expiry and latches
// a sticky timeout that only reset clears.
module mem_wait_watchdog #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_waiting,
    input  logic i_ready,
    input  logic i_clear,
    output logic o_expire,
    output logic o_timeout
);
    localparam int CW = $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    // Expiry is the WAIT_LIMIT-th stalled cycle; ready in that cycle still wins.
    assign o_expire  = i_waiting && !i_ready && (r_cnt == CW'(WAIT_LIMIT - 1));
    assign o_timeout = r_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (i_clear)
                r_cnt <= '0;
            else if (i_waiting && !i_ready)
                r_cnt <= r_cnt + CW'(1);
            if (o_expire)
                r_timeout <= 1'b1;
        end
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath: sequences fetch,
// decode, execute, memory and writeback, and counts retired instructions.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mips_multicycle_ctrl_if.slave bus
);
    state_t           r_state;
    state_t           w_next;
    ctrl_out_t        r_out;
    logic [CNT_W-1:0] r_count;
    logic             w_waiting;
    logic             w_enter_wait;
    logic             w_expire;
    logic             w_retire;
    logic             w_timeout;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = FETCH;
            FETCH:    if (bus.mem_ready) w_next = DECODE;
                      else if (w_expire) w_next = HALT;
            DECODE:   case (bus.opcode)
                          OP_LW, OP_SW: w_next = MEM_ADDR;
                          OP_RTYPE:     w_next = EXEC;
                          OP_BEQ:       w_next = BRANCH;
                          OP_J:         w_next = JUMP;
                          OP_ADDI:      w_next = ADDI_EX;
                          default:      w_next = FETCH;
                      endcase
            MEM_ADDR: w_next = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (bus.mem_ready) w_next = MEM_WB;
                      else if (w_expire) w_next = HALT;
            MEM_WR:   if (bus.mem_ready) w_next = FETCH;
                      else if (w_expire) w_next = HALT;
            EXEC:     w_next = R_WB;
            ADDI_EX:  w_next = ADDI_WB;
            MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: w_next = FETCH;
            HALT:     w_next = HALT;
            default:  w_next = IDLE;
        endcase
    end

    assign w_waiting    = (r_state == FETCH) || (r_state == MEM_RD) || (r_state == MEM_WR);
    assign w_enter_wait = (w_next != r_state) &&
                          ((w_next == FETCH) || (w_next == MEM_RD) || (w_next == MEM_WR));
    // MEM_WR only reaches FETCH on a completed store, so this is exactly retirement.
    assign w_retire     = (w_next == FETCH) &&
                          (r_state inside {MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, ADDI_WB});

    mem_wait_watchdog #(.WAIT_LIMIT(WAIT_LIMIT)) u_wdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_waiting (w_waiting),
        .i_ready   (bus.mem_ready),
        .i_clear   (w_enter_wait),
        .o_expire  (w_expire),
        .o_timeout (w_timeout)
    );

    // Control word is registered from the next state so it is valid for the
    // whole cycle the state is occupied, and clears with the async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_out   <= state_outputs(w_next);
            if (w_retire)
                r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.iord        = r_out.iord;
    assign bus.mem_read    = r_out.mem_read;
    assign bus.mem_write   = r_out.mem_write;
    assign bus.reg_dst     = r_out.reg_dst;
    assign bus.mem_to_reg  = r_out.mem_to_reg;
    assign bus.reg_write   = r_out.reg_write;
    assign bus.alu_src_a   = r_out.alu_src_a;
    assign bus.alu_src_b   = r_out.alu_src_b;
    assign bus.alu_op      = r_out.alu_op;
    assign bus.pc_source   = r_out.pc_source;
    assign bus.ir_write    = (r_state == FETCH) && bus.mem_ready;
    assign bus.pc_en       = ((r_state == FETCH) && bus.mem_ready) ||
                             ((r_state == BRANCH) && bus.zero) || (r_state == JUMP);
    assign bus.illegal     = (r_state == DECODE) && !is_legal(bus.opcode);
    assign bus.mem_timeout = w_timeout;
    assign bus.state       = r_state;
    assign bus.instr_count = r_count;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-by-cycle bench for the MIPS control FSM: each step queues the
// expected state/control/count word and the observed one for comparison.
module tb_mips_multicycle_ctrl;
    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
                           S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_EXEC = 4'd7,
                           S_R_WB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ADDI_EX = 4'd11,
                           S_ADDI_WB = 4'd12, S_HALT = 4'd13;
    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                           BEQ = 6'b000100, JJ = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_W(4)) bus();
    mips_multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    logic [24:0] exp_q[$];
    logic [24:0] obs_q[$];
    logic [24:0] e, o;
    logic [3:0]  exp_cnt;
    logic [3:0]  prev_st;
    logic        exp_to;

    // {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
    //  reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], illegal}
    function automatic logic [15:0] spec_vec(logic [3:0] st, logic rdy, logic z, logic [5:0] op);
        logic pe, io, mr, mw, irw, rd, m2r, rw, sa, ill;
        logic [1:0] sb, ao, ps;
        {pe, io, mr, mw, irw, rd, m2r, rw, sa, ill} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            S_FETCH:    begin mr = 1; sb = 2'b01; irw = rdy; pe = rdy; end
            S_DECODE:   begin sb = 2'b11;
                              ill = !(op inside {RT, LW, SW, BEQ, JJ, ADDI}); end
            S_MEM_ADDR: begin sa = 1; sb = 2'b10; end
            S_MEM_RD:   begin mr = 1; io = 1; end
            S_MEM_WB:   begin rw = 1; m2r = 1; end
            S_MEM_WR:   begin mw = 1; io = 1; end
            S_EXEC:     begin sa = 1; ao = 2'b10; end
            S_R_WB:     begin rw = 1; rd = 1; end
            S_BRANCH:   begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
            S_JUMP:     begin ps = 2'b10; pe = 1; end
            S_ADDI_EX:  begin sa = 1; sb = 2'b10; end
            S_ADDI_WB:  rw = 1;
            default:    ;
        endcase
        return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, ill};
    endfunction

    function automatic logic [24:0] observe();
        return {bus.state, bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_source, bus.illegal, bus.instr_count, bus.mem_timeout};
    endfunction

    task automatic step(input logic rdy, input logic z, input logic [5:0] op, input logic [3:0] est);
        @(negedge clk);
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.opcode    = op;
        if (est == S_FETCH && (prev_st inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB}))
            exp_cnt = exp_cnt + 4'd1;
        exp_q.push_back({est, spec_vec(est, rdy, z, op), exp_cnt, exp_to});
        prev_st = est;
        #1;
        obs_q.push_back(observe());
    endtask

    task automatic test_reset();
        bus.opcode = RT; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if (observe() !== 25'h0) begin failures++; $display("FAIL reset_hold got=%h exp=%h", observe(), 25'h0); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (observe() !== 25'h0) begin failures++; $display("FAIL reset_idle got=%h exp=%h", observe(), 25'h0); end
        exp_cnt = 4'd0; prev_st = S_IDLE; exp_to = 1'b0;
    endtask

    task automatic test_rtype();
        step(1, 0, RT, S_FETCH); step(1, 0, RT, S_DECODE);
        step(1, 0, RT, S_EXEC);  step(1, 0, RT, S_R_WB);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL rtype got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_lw_stall();
        repeat (3) step(0, 0, LW, S_FETCH);
        step(1, 0, LW, S_FETCH); step(1, 0, LW, S_DECODE); step(1, 0, LW, S_MEM_ADDR);
        repeat (2) step(0, 0, LW, S_MEM_RD);
        step(1, 0, LW, S_MEM_RD); step(1, 0, LW, S_MEM_WB);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL lw_stall got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_beq();
        step(1, 0, BEQ, S_FETCH); step(1, 0, BEQ, S_DECODE); step(1, 1, BEQ, S_BRANCH);
        step(1, 1, BEQ, S_FETCH); step(1, 1, BEQ, S_DECODE); step(1, 0, BEQ, S_BRANCH);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL beq got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_illegal();
        step(1, 0, BAD, S_FETCH); step(1, 0, BAD, S_DECODE);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL illegal got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_sw_addi_j();
        step(1, 0, SW, S_FETCH);   step(1, 0, SW, S_DECODE);
        step(1, 0, SW, S_MEM_ADDR); step(1, 0, SW, S_MEM_WR);
        step(1, 0, ADDI, S_FETCH); step(1, 0, ADDI, S_DECODE);
        step(1, 0, ADDI, S_ADDI_EX); step(1, 0, ADDI, S_ADDI_WB);
        step(1, 0, JJ, S_FETCH);   step(1, 0, JJ, S_DECODE); step(1, 0, JJ, S_JUMP);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL sw_addi_j got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_wdog_edge();
        step(1, 0, SW, S_FETCH); step(1, 0, SW, S_DECODE); step(1, 0, SW, S_MEM_ADDR);
        repeat (3) step(0, 0, SW, S_MEM_WR);
        step(1, 0, SW, S_MEM_WR);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL wdog_edge got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, JJ, S_FETCH); step(1, 0, JJ, S_DECODE); step(1, 0, JJ, S_JUMP);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL back_to_back got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_mid_reset();
        step(1, 0, LW, S_FETCH); step(1, 0, LW, S_DECODE);
        step(1, 0, LW, S_MEM_ADDR); step(0, 0, LW, S_MEM_RD);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL mid_reset_pre got=%h exp=%h", o, e); end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (observe() !== 25'h0) begin failures++; $display("FAIL mid_reset_async got=%h exp=%h", observe(), 25'h0); end
        @(negedge clk);
        reset_n = 1'b1;
        exp_cnt = 4'd0; prev_st = S_IDLE; exp_to = 1'b0;
    endtask

    task automatic test_timeout();
        step(1, 0, SW, S_FETCH); step(1, 0, SW, S_DECODE); step(1, 0, SW, S_MEM_ADDR);
        repeat (4) step(0, 0, SW, S_MEM_WR);
        exp_to = 1'b1;
        repeat (3) step(1, 0, SW, S_HALT);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL timeout got=%h exp=%h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_illegal();
        test_sw_addi_j();
        test_wdog_edge();
        test_back_to_back();
        test_mid_reset();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
